cpu_int_ctrl: RTL and testbench

//  Parametrised interrupt controller for the 6502-class core: replaces the fixed single-IRQ/NMI logic.

---
 rtl/cpu_int_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_int_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/cpu_int_ctrl.sv
// Interrupt controller for the 6502-class core: synchronises IRQ/NMI pins, arbitrates
// reset > NMI > IRQ at instruction boundaries and hands a frozen request to the sequencer.
module cpu_int_ctrl #(
  parameter int                ADDR_N      = 16,
  parameter int                NUM_IRQ     = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [ADDR_N-1:0] RESET_VEC   = 16'hfffc,
  parameter logic [ADDR_N-1:0] NMI_VEC     = 16'hfffa,
  parameter logic [ADDR_N-1:0] IRQ_VEC     = 16'hfffe,
  localparam int               SRC_W       = $clog2(NUM_IRQ) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_n_i,
  input  logic               nmi_n_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               i_flag_i,
  input  logic               poll_i,
  input  logic               int_ack_i,
  input  logic               int_done_i,
  output logic               int_req_o,
  output logic [1:0]         int_type_o,
  output logic [ADDR_N-1:0]  int_vec_o,
  output logic [SRC_W-1:0]   int_src_o,
  output logic [NUM_IRQ-1:0] irq_pending_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;
  localparam logic [1:0] T_NONE = 2'b00, T_RST = 2'b01, T_NMI = 2'b10, T_IRQ = 2'b11;

  logic [NUM_IRQ-1:0] irq_sync;
  logic               nmi_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_sync = irq_n_i;
      assign nmi_sync = nmi_n_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_ff_q;
      logic [SYNC_STAGES-1:0]              nmi_ff_q;
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          irq_ff_q <= '1;
          nmi_ff_q <= '1;
        end else begin
          irq_ff_q[0] <= irq_n_i;
          nmi_ff_q[0] <= nmi_n_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            irq_ff_q[i] <= irq_ff_q[i-1];
            nmi_ff_q[i] <= nmi_ff_q[i-1];
          end
        end
      end
      assign irq_sync = irq_ff_q[SYNC_STAGES-1];
      assign nmi_sync = nmi_ff_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t             state_q;
  logic               reset_pend_q, nmi_pend_q, nmi_prev_q, nmi_edge_q;
  logic [NUM_IRQ-1:0] irq_pending_q;
  logic               int_req_q;
  logic [1:0]         int_type_q;
  logic [ADDR_N-1:0]  int_vec_q;
  logic [SRC_W-1:0]   int_src_q;

  logic               irq_cand;
  logic [SRC_W-1:0]   irq_idx;

  // Lowest-index pending source wins; scan downward so the last hit is the lowest.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_pending_q[i]) irq_idx = SRC_W'(i);
  end
  assign irq_cand = (|irq_pending_q) & ~i_flag_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      reset_pend_q  <= 1'b1;
      nmi_pend_q    <= 1'b0;
      nmi_prev_q    <= 1'b1;
      nmi_edge_q    <= 1'b0;
      irq_pending_q <= '0;
      int_req_q     <= 1'b0;
      int_type_q    <= T_NONE;
      int_vec_q     <= '0;
      int_src_q     <= '0;
    end else begin
      nmi_prev_q    <= nmi_sync;
      nmi_edge_q    <= nmi_prev_q & ~nmi_sync;
      irq_pending_q <= ~irq_sync & irq_en_i;
      case (state_q)
        S_IDLE: if (poll_i) begin
          if (reset_pend_q) begin
            state_q <= S_REQ; int_req_q <= 1'b1;
            int_type_q <= T_RST; int_vec_q <= RESET_VEC; int_src_q <= '0;
          end else if (nmi_pend_q) begin
            state_q <= S_REQ; int_req_q <= 1'b1;
            int_type_q <= T_NMI; int_vec_q <= NMI_VEC; int_src_q <= '0;
          end else if (irq_cand) begin
            state_q <= S_REQ; int_req_q <= 1'b1;
            int_type_q <= T_IRQ; int_vec_q <= IRQ_VEC; int_src_q <= irq_idx;
          end
        end
        S_REQ: begin
          if (int_ack_i) begin
            state_q   <= S_SVC;
            int_req_q <= 1'b0;
            if (int_type_q == T_RST) reset_pend_q <= 1'b0;
            if (int_type_q == T_NMI) nmi_pend_q   <= 1'b0;
          end else if (int_type_q == T_IRQ && nmi_pend_q) begin
            int_type_q <= T_NMI; int_vec_q <= NMI_VEC; int_src_q <= '0;
          end
        end
        S_SVC: if (int_done_i) begin
          state_q <= S_IDLE;
          int_type_q <= T_NONE; int_vec_q <= '0; int_src_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
      // A new edge coincident with the clearing ack must not be lost.
      if (nmi_edge_q) nmi_pend_q <= 1'b1;
    end
  end

  assign int_req_o     = int_req_q;
  assign int_type_o    = int_type_q;
  assign int_vec_o     = int_vec_q;
  assign int_src_o     = int_src_q;
  assign irq_pending_o = irq_pending_q;
  assign busy_o        = (state_q != S_IDLE);
endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl (default parameters, SYNC_STAGES=2).
module tb_cpu_int_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_n, irq_en, irq_pending;
  logic        nmi_n, i_flag, poll, int_ack, int_done;
  logic        int_req, busy;
  logic [1:0]  int_type;
  logic [15:0] int_vec;
  logic [2:0]  int_src;
  int n_assert = 0;
  int n_fail   = 0;

  cpu_int_ctrl dut (
    .clk_i(clk), .reset_i(reset), .irq_n_i(irq_n), .nmi_n_i(nmi_n), .irq_en_i(irq_en),
    .i_flag_i(i_flag), .poll_i(poll), .int_ack_i(int_ack), .int_done_i(int_done),
    .int_req_o(int_req), .int_type_o(int_type), .int_vec_o(int_vec), .int_src_o(int_src),
    .irq_pending_o(irq_pending), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; irq_n = 4'hf; nmi_n = 1; irq_en = 4'h0; i_flag = 1;
    poll = 0; int_ack = 0; int_done = 0;
    step(3);
    chk("rst_req", int_req, 0);  chk("rst_type", int_type, 0);
    chk("rst_vec", int_vec, 0);  chk("rst_src", int_src, 0);
    chk("rst_pend", irq_pending, 0); chk("rst_busy", busy, 0);

    // reset service
    reset = 0; poll = 1; step(1);
    chk("rv_req", int_req, 1); chk("rv_type", int_type, 1);
    chk("rv_vec", int_vec, 16'hfffc); chk("rv_busy", busy, 1);
    poll = 0; int_ack = 1; step(1);
    chk("rv_ack_req", int_req, 0); chk("rv_svc_busy", busy, 1); chk("rv_svc_type", int_type, 1);
    int_ack = 0; int_done = 1; step(1);
    int_done = 0;
    chk("rv_done_type", int_type, 0); chk("rv_done_busy", busy, 0);
    poll = 1; step(1); poll = 0;
    chk("idle_nocand", int_req, 0);

    // IRQ source 2
    irq_n = 4'b1011; irq_en = 4'hf; step(3);
    chk("irq2_pend", irq_pending, 4'b0100);
    poll = 1; step(1); poll = 0;
    chk("iflag_mask", int_req, 0);
    i_flag = 0; poll = 1; step(1); poll = 0;
    chk("irq2_req", int_req, 1); chk("irq2_type", int_type, 3);
    chk("irq2_src", int_src, 2); chk("irq2_vec", int_vec, 16'hfffe);
    int_ack = 1; step(1); int_ack = 0; int_done = 1; step(1); int_done = 0;
    chk("irq2_idle", busy, 0);

    // source 0 disabled, source 3 wins
    irq_n = 4'b0110; irq_en = 4'b1110; step(3);
    chk("irq3_pend", irq_pending, 4'b1000);
    poll = 1; step(1); poll = 0;
    chk("irq3_type", int_type, 3); chk("irq3_src", int_src, 3);

    // IRQ drops (frozen), NMI hijacks after SYNC_STAGES+3 cycles
    irq_n = 4'hf; nmi_n = 0; step(4);
    chk("hj_frozen_type", int_type, 3); chk("hj_frozen_req", int_req, 1);
    step(1);
    chk("hj_type", int_type, 2); chk("hj_vec", int_vec, 16'hfffa);
    chk("hj_src", int_src, 0); chk("hj_req", int_req, 1);
    int_ack = 1; step(1); int_ack = 0;
    chk("hj_svc_req", int_req, 0);

    // second NMI edge during SERVICE
    nmi_n = 1; step(3);
    nmi_n = 0; step(5);
    chk("nmi2_svc_type", int_type, 2);
    int_done = 1; step(1); int_done = 0;
    chk("nmi2_idle_type", int_type, 0); chk("nmi2_idle_busy", busy, 0);
    poll = 1; step(1); poll = 0;
    chk("nmi2_req", int_req, 1); chk("nmi2_type", int_type, 2);
    int_ack = 1; step(1); int_ack = 0; int_done = 1; step(1); int_done = 0;
    poll = 1; step(1); poll = 0;
    chk("nmi_held_noretrig", int_req, 0);

    // reset during SERVICE
    irq_n = 4'b1110; irq_en = 4'hf; step(3);
    poll = 1; step(1); poll = 0;
    chk("irq0_type", int_type, 3); chk("irq0_src", int_src, 0);
    int_ack = 1; step(1); int_ack = 0;
    chk("irq0_svc_busy", busy, 1);
    reset = 1; step(1);
    chk("mid_rst_req", int_req, 0); chk("mid_rst_type", int_type, 0);
    chk("mid_rst_vec", int_vec, 0); chk("mid_rst_src", int_src, 0);
    chk("mid_rst_pend", irq_pending, 0); chk("mid_rst_busy", busy, 0);
    reset = 0; poll = 1; step(1); poll = 0;
    chk("post_rst_type", int_type, 1); chk("post_rst_vec", int_vec, 16'hfffc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
